// File: rtl/banked_coderom.sv
// Multi-bank code ROM with a run-time byte-serial download port and a fixed-latency read pipeline.
// Reads are only enabled once a complete image has been downloaded (state READY).
module banked_coderom #(
    parameter int unsigned AW      = 13,
    parameter int unsigned DW      = 8,
    parameter int unsigned NBANKS  = 4,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned PRELOAD = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     a,
    input  logic [NBANKS-1:0] ce_n,
    output logic [DW-1:0]     out,
    output logic              out_valid,
    input  logic              dn_download,
    input  logic              dn_wr,
    input  logic [AW+2:0]     dn_addr,
    input  logic [DW-1:0]     dn_data,
    output logic              ready,
    output logic              loading,
    output logic              err_multi,
    output logic              err_ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READY
    } state_e;

    localparam state_e     RST_STATE = (PRELOAD != 0) ? S_READY : S_IDLE;
    localparam logic [3:0] NB        = 4'(NBANKS);

    state_e      state_q, state_d;
    logic        err_multi_q, err_multi_d;
    logic        err_ovf_q, err_ovf_d;
    logic [2:0]  dn_bank;
    logic        wr_en;
    logic        bank_ovf;
    logic [DW-1:0] bank_rd [NBANKS];
    logic [DW-1:0] sel_data;
    logic        hit;
    logic [DW-1:0] data_d;
    logic        valid_d;
    logic [DW-1:0] pipe_data_q  [LATENCY];
    logic        pipe_valid_q [LATENCY];

    assign dn_bank  = dn_addr[AW+2:AW];
    assign wr_en    = reset_n && (state_q == S_LOAD) && dn_wr;
    assign bank_ovf = wr_en && ({1'b0, dn_bank} >= NB);

    // Memory is never reset so an image survives a reset.
    for (genvar g = 0; g < NBANKS; g++) begin : g_bank
        logic [DW-1:0] mem_q [2**AW];

        always_ff @(posedge clk) begin
            if (wr_en && (dn_bank == 3'(g))) begin
                mem_q[dn_addr[AW-1:0]] <= dn_data;
            end
        end

        assign bank_rd[g] = mem_q[a];
    end

    always_comb begin
        sel_data = '0;
        hit      = 1'b0;
        for (int unsigned i = 0; i < NBANKS; i++) begin
            if (!hit && !ce_n[i]) begin
                hit      = 1'b1;
                sel_data = bank_rd[i];
            end
        end
        data_d  = '0;
        valid_d = 1'b0;
        if ((state_q == S_READY) && hit) begin
            data_d  = sel_data;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        err_multi_d = err_multi_q | ((state_q == S_READY) && ($countones(~ce_n) > 1));
        err_ovf_d   = err_ovf_q | bank_ovf;
        case (state_q)
            S_IDLE:  if (dn_download)  state_d = S_LOAD;
            S_LOAD:  if (!dn_download) state_d = S_READY;
            S_READY: if (dn_download)  state_d = S_LOAD;
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= RST_STATE;
            err_multi_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_data_q[i]  <= '0;
                pipe_valid_q[i] <= 1'b0;
            end
        end else begin
            state_q         <= state_d;
            err_multi_q     <= err_multi_d;
            err_ovf_q       <= err_ovf_d;
            pipe_data_q[0]  <= data_d;
            pipe_valid_q[0] <= valid_d;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_data_q[i]  <= pipe_data_q[i-1];
                pipe_valid_q[i] <= pipe_valid_q[i-1];
            end
        end
    end

    assign out       = pipe_data_q[LATENCY-1];
    assign out_valid = pipe_valid_q[LATENCY-1];
    assign ready     = (state_q == S_READY);
    assign loading   = (state_q == S_LOAD);
    assign err_multi = err_multi_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_banked_coderom.sv
// Bench for banked_coderom: LATENCY=1 and LATENCY=3 instances share stimulus and are checked
// each cycle against a behavioural model, plus directed literal expectations.
module tb_banked_coderom;

    logic        clk;
    logic        reset_n;
    logic [12:0] a;
    logic [3:0]  ce_n;
    logic        dn_download;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;

    logic [7:0] o1, o3;
    logic       v1, v3, rdy1, rdy3, ld1, ld3, em1, em3, eo1, eo3;

    int n_checks = 0;
    int n_err    = 0;

    banked_coderom #(.AW(13), .DW(8), .NBANKS(4), .LATENCY(1), .PRELOAD(0)) u_l1 (
        .clk(clk), .reset_n(reset_n), .a(a), .ce_n(ce_n), .out(o1), .out_valid(v1),
        .dn_download(dn_download), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
        .ready(rdy1), .loading(ld1), .err_multi(em1), .err_ovf(eo1)
    );

    banked_coderom #(.AW(13), .DW(8), .NBANKS(4), .LATENCY(3), .PRELOAD(0)) u_l3 (
        .clk(clk), .reset_n(reset_n), .a(a), .ce_n(ce_n), .out(o3), .out_valid(v3),
        .dn_download(dn_download), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
        .ready(rdy3), .loading(ld3), .err_multi(em3), .err_ovf(eo3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: 0=IDLE 1=LOAD 2=READY; h_* holds the last three read results, newest first.
    logic [7:0] ref_mem   [4][8192];
    bit         ref_known [4][8192];
    int         m_state = 0;
    bit         m_multi = 0, m_ovf = 0, m_init = 0;
    logic [7:0] h_d [3];
    bit         h_v [3];
    bit         h_k [3];

    initial begin
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8192; i++) ref_known[b][i] = 0;
    end

    always @(posedge clk) begin
        bit found, rv, rk;
        logic [7:0] rd;
        int bank, off;
        if (!reset_n) begin
            m_state = 0;
            m_multi = 0;
            m_ovf   = 0;
            m_init  = 1;
            for (int i = 0; i < 3; i++) begin
                h_d[i] = 8'h00; h_v[i] = 0; h_k[i] = 1;
            end
        end else begin
            found = 0; rv = 0; rk = 1; rd = 8'h00;
            if (m_state == 2) begin
                for (int i = 0; i < 4; i++) begin
                    if (!found && !ce_n[i]) begin
                        found = 1; rv = 1;
                        rd = ref_mem[i][a];
                        rk = ref_known[i][a];
                    end
                end
            end
            for (int i = 2; i > 0; i--) begin
                h_d[i] = h_d[i-1]; h_v[i] = h_v[i-1]; h_k[i] = h_k[i-1];
            end
            h_d[0] = rd; h_v[0] = rv; h_k[0] = rk;
            if (m_state == 2 && $countones(~ce_n) > 1) m_multi = 1;
            if (m_state == 1 && dn_wr) begin
                bank = int'(dn_addr[15:13]);
                off  = int'(dn_addr[12:0]);
                if (bank < 4) begin
                    ref_mem[bank][off]   = dn_data;
                    ref_known[bank][off] = 1;
                end else begin
                    m_ovf = 1;
                end
            end
            case (m_state)
                0: if (dn_download)  m_state = 1;
                1: if (!dn_download) m_state = 2;
                default: if (dn_download) m_state = 1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("m_l1_valid", v1, h_v[0]);
            if (h_k[0]) chk("m_l1_out", o1, h_d[0]);
            chk("m_l3_valid", v3, h_v[2]);
            if (h_k[2]) chk("m_l3_out", o3, h_d[2]);
            chk("m_ready", {rdy3, rdy1}, {2{m_state == 2}});
            chk("m_loading", {ld3, ld1}, {2{m_state == 1}});
            chk("m_err_multi", {em3, em1}, {2{m_multi}});
            chk("m_err_ovf", {eo3, eo1}, {2{m_ovf}});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        dn_wr = 1'b1; dn_addr = addr; dn_data = data;
        tick();
        dn_wr = 1'b0;
    endtask

    task automatic rd1(input logic [3:0] ce, input logic [12:0] addr, input logic [7:0] exp,
                       input string nm);
        ce_n = ce; a = addr;
        @(posedge clk);
        #1;
        chk(nm, o1, exp);
        chk({nm, "_valid"}, v1, 1);
        #1;
    endtask

    logic [3:0]  bb_ce  [4] = '{4'b1101, 4'b0111, 4'b1011, 4'b1110};
    logic [12:0] bb_a   [4] = '{13'h0010, 13'h1FFF, 13'h0010, 13'h0005};
    logic [7:0]  bb_exp [4] = '{8'hA5, 8'h3C, 8'h77, 8'h11};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; a = '0; ce_n = 4'hF; dn_download = 0; dn_wr = 0; dn_addr = '0; dn_data = '0;
        repeat (3) tick();
        chk("rst_ready", rdy1, 0);
        chk("rst_loading", ld1, 0);
        chk("rst_out", {o3, o1}, 0);
        chk("rst_valid", {v3, v1}, 0);
        chk("rst_errs", {em1, eo1}, 0);

        reset_n = 1; ce_n = 4'b1110; a = '0;
        tick(); tick();
        chk("idle_valid", v1, 0);
        chk("idle_out", o1, 0);
        chk("idle_ready", rdy1, 0);

        dn_download = 1; ce_n = 4'hF;
        tick();
        chk("loading", ld1, 1);
        wr({3'd1, 13'h0010}, 8'hA5);
        wr({3'd3, 13'h1FFF}, 8'h3C);
        wr({3'd0, 13'h0005}, 8'h11);
        wr({3'd1, 13'h0005}, 8'h22);
        wr({3'd2, 13'h0010}, 8'h77);
        chk("ovf_clear", eo1, 0);
        wr({3'd6, 13'h0010}, 8'hFF);
        chk("ovf_set", eo1, 1);
        chk("ready_in_load", rdy1, 0);

        dn_download = 0;
        tick();
        chk("ready_after_load", rdy1, 1);
        chk("loading_after_load", ld1, 0);

        rd1(4'b1101, 13'h0010, 8'hA5, "rd_bank1");
        rd1(4'b0111, 13'h1FFF, 8'h3C, "rd_bank3_top");
        rd1(4'b1011, 13'h0010, 8'h77, "rd_bank2_not_ovf");

        for (int j = 0; j < 7; j++) begin
            if (j < 4) begin
                ce_n = bb_ce[j]; a = bb_a[j];
            end else begin
                ce_n = 4'hF;
            end
            @(posedge clk);
            #1;
            if (j >= 2 && j < 6) begin
                chk("lat3_out", o3, bb_exp[j-2]);
                chk("lat3_valid", v3, 1);
            end
            if (j == 6) chk("lat3_tail_valid", v3, 0);
            #1;
        end

        ce_n = 4'b1100; a = 13'h0005;
        @(posedge clk); #1;
        chk("prio_out", o1, 8'h11);
        chk("multi_set", em1, 1);
        #1;
        ce_n = 4'hF;
        @(posedge clk); #1;
        chk("none_valid", v1, 0);
        chk("none_out", o1, 0);
        chk("multi_sticky", em1, 1);
        #1;

        ce_n = 4'b1101; a = 13'h0010; dn_download = 1;
        @(posedge clk); #1;
        chk("enter_load_rd", o1, 8'hA5);
        chk("enter_load_valid", v1, 1);
        chk("enter_load_loading", ld1, 1);
        #1;
        tick();
        chk("load_rd_blocked", v1, 0);
        dn_download = 0;
        @(posedge clk); #1;
        chk("reenter_ready", rdy1, 1);
        chk("reenter_rd_invalid", v1, 0);
        #1;
        @(posedge clk); #1;
        chk("ready_rd_valid", v1, 1);
        chk("ready_rd_out", o1, 8'hA5);
        #1;

        ce_n = 4'hF; dn_download = 1;
        tick(); tick();
        chk("mid_loading", ld1, 1);
        reset_n = 0; dn_download = 0;
        tick();
        reset_n = 1;
        chk("mr_loading", ld1, 0);
        chk("mr_ready", rdy1, 0);
        chk("mr_pipe", {o3, v3, o1, v1}, 0);
        chk("mr_errs", {em1, eo1}, 0);
        ce_n = 4'b1110; a = 13'h0005;
        tick(); tick();
        chk("mr_still_idle", rdy1, 0);
        chk("mr_rd_blocked", v1, 0);

        dn_download = 1;
        tick();
        dn_download = 0;
        tick();
        chk("fresh_ready", rdy1, 1);
        rd1(4'b1110, 13'h0005, 8'h11, "rd_kept_image");
        ce_n = 4'hF;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
